mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported synchronous RAM between three requesters: instruction fetch (IF, read-only), the pipeline MEM stage (DM, read/write), and a debug/program loader (DBG, read/write). Each cycle it picks at most one winner and drives the RAM-side port. It tags the outstanding read so the returned data goes back to its owner. It also produces per-requester stall signals; the pipeline uses these to freeze the PC and pipeline registers, as it does for load-use.

Parameters:
WIDTH, 32, data width in bits.
ADDR_W, 32, byte address width.
STARVE_MAX, 4, consecutive denied IF cycles before IF is promoted to top priority (1..15).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
if_req  in  1  fetch request.
if_addr  in  ADDR_W  fetch byte address.
if_gnt  out  1  fetch granted this cycle (combinational).
if_rvalid  out  1  fetch read data valid (registered).
if_stall  out  1  if_req && !if_gnt.
dm_req, dm_we  in  1 each  data request / write enable.
dm_mode  in  2  access size: 0 byte, 1 half, 2 word (passed through).
dm_addr  in  ADDR_W  data address.
dm_wdata  in  WIDTH  store data.
dm_gnt, dm_rvalid, dm_stall  out  1 each  as for IF.
dbg_req, dbg_we  in  1 each  loader request / write enable.
dbg_lock  in  1  loader holds the port across cycles.
dbg_addr  in  ADDR_W  loader address.
dbg_wdata  in  WIDTH  loader write data.
dbg_gnt, dbg_rvalid, dbg_stall  out  1 each  as for IF.
rdata  out  WIDTH  shared read-data return, qualified by the *_rvalid signals.
mem_en, mem_we  out  1 each  RAM enable / write enable.
mem_mode  out  2  RAM access size.
mem_addr  out  ADDR_W  RAM address.
mem_wdata  out  WIDTH  RAM write data.
mem_rdata  in  WIDTH  RAM read data, valid one cycle after a read is issued.

Behaviour:
- Reset (rst low, asynchronous): owner register = NONE, starve_cnt = 0, lock_active = 0, all *_rvalid = 0. The combinational outputs follow the rules below with lock_active = 0. A read in flight when reset asserts is discarded; no rvalid is produced after reset releases.
- Priority order, evaluated each cycle:
  1. DBG when lock_active.
  2. IF when starve_cnt == STARVE_MAX.
  3. DBG.
  4. DM.
  5. IF.
- Exactly one grant or none. gnt is set only for a requester with req = 1. A non-requesting port is never granted.
- While lock_active is set, IF and DM are never granted, even when DBG does not request in that cycle.
- lock_active: set on a cycle with dbg_gnt && dbg_lock; cleared on the first cycle with dbg_lock = 0.
- RAM drive: mem_en = any grant; mem_we/mem_addr/mem_wdata/mem_mode come from the winner. IF forces we = 0 and mode = 2; DBG forces mode = 2. With no grant, mem_we = 0 and the data buses are don't-care but stable (hold the IF values).
- Read latency is 1:
  - A granted read (we = 0) sets owner <= winner.
  - Next cycle: the owner's rvalid = 1 and rdata = mem_rdata.
  - Writes and idle cycles set owner <= NONE.
  - Back-to-back reads are allowed every cycle. No bubble is required.
- Write then read of the same address in consecutive cycles returns the new data; this relies on RAM write-first semantics and needs no arbiter logic.
- starve_cnt (4-bit, saturating):
  - if_gnt → 0.
  - if_req && !if_gnt → min(cnt + 1, STARVE_MAX).
  - !if_req → hold.
- Stalls are purely combinational: *_stall = *_req && !*_gnt.

Decomposition:
- Shared package: owner enum OWN_NONE/OWN_IF/OWN_DM/OWN_DBG; ram mode constants RAM_BYTE/RAM_HALF/RAM_WORD, reused by RAM and Controller.
- One sub-module, mem_prio_pick: combinational fixed-priority selector taking the req vector, lock and starve flag, and returning a one-hot gnt. The top level holds the registers and muxes.

Test Plan:
- Release reset with no requests → all gnt/rvalid 0, mem_en 0; assert rst low mid-read (IF read at 0x40 issued) → no if_rvalid the next cycle.
- IF and DM both request reads (IF 0x00, DM 0x100, RAM preloaded 0xDEADBEEF at 0x100) → dm_gnt = 1, if_stall = 1; next cycle dm_rvalid = 1, rdata = 0xDEADBEEF, if_rvalid = 0.
- DM requests every cycle, IF requests continuously, STARVE_MAX = 4 → IF denied 4 cycles, granted on the 5th; starve_cnt returns to 0; DM is stalled that cycle.
- DBG writes 0x12345678 to 0x200 with dbg_lock = 1 for 3 cycles, IF/DM requesting → only dbg_gnt is seen for those cycles plus the cycle dbg_lock drops; DM read of 0x200 afterwards returns 0x12345678.
- DM byte write (mode 0) to 0x301 followed by an immediate DM read → mem_mode = 0 on the write, back-to-back grants, dm_rvalid the cycle after the read.
- Alternating IF/DM reads every cycle → rvalid always lands on the port that was granted one cycle earlier; never two rvalids in the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the single-port RAM arbiter: read-owner tags,
// RAM access-size codes and requester bit positions.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_DBG  = 2'd3
    } owner_e;

    localparam logic [1:0] RAM_BYTE = 2'd0;
    localparam logic [1:0] RAM_HALF = 2'd1;
    localparam logic [1:0] RAM_WORD = 2'd2;

    // Bit positions inside the request / grant vectors.
    localparam int REQ_IF  = 0;
    localparam int REQ_DM  = 1;
    localparam int REQ_DBG = 2;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
        logic [3:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Fixed-priority winner selection: locked loader, starved fetch, loader,
// data stage, fetch. Returns a one-hot (or all-zero) grant vector.
module mem_prio_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic       lock,
    input  logic       starve,
    output logic [2:0] gnt
);

    // Priority chain; a locked port never yields to IF or DM even when DBG is idle.
    always_comb begin
        gnt = 3'b000;
        if (lock) begin
            gnt[REQ_DBG] = req[REQ_DBG];
        end else if (starve && req[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end else if (req[REQ_DBG]) begin
            gnt[REQ_DBG] = 1'b1;
        end else if (req[REQ_DM]) begin
            gnt[REQ_DM] = 1'b1;
        end else if (req[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end else begin
            gnt = 3'b000;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF / DM / DBG onto one single-ported synchronous RAM, tags the
// outstanding read for return routing, and raises per-requester stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_mode,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [WIDTH-1:0]  dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic              dm_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [WIDTH-1:0]  dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic              dbg_stall,
    output logic [WIDTH-1:0]  rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [2:0] req_s;
    logic [2:0] gnt_s;
    logic       starve_s;
    owner_e     win_s;
    owner_e     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       lock_q, lock_d;

    assign req_s    = {dbg_req, dm_req, if_req};
    assign starve_s = (starve_q == STARVE_LIM);

    mem_prio_pick u_pick (
        .req    (req_s),
        .lock   (lock_q),
        .starve (starve_s),
        .gnt    (gnt_s)
    );

    // Grant and stall outputs straight from the selector.
    always_comb begin
        if_gnt    = gnt_s[REQ_IF];
        dm_gnt    = gnt_s[REQ_DM];
        dbg_gnt   = gnt_s[REQ_DBG];
        if_stall  = if_req  && !gnt_s[REQ_IF];
        dm_stall  = dm_req  && !gnt_s[REQ_DM];
        dbg_stall = dbg_req && !gnt_s[REQ_DBG];
    end

    // RAM-side mux; idle cycles park on the IF address so the bus stays quiet.
    always_comb begin
        mem_en    = |gnt_s;
        mem_we    = 1'b0;
        mem_mode  = RAM_WORD;
        mem_addr  = if_addr;
        mem_wdata = '0;
        win_s     = OWN_NONE;
        case (gnt_s)
            3'b001: begin
                win_s = OWN_IF;
            end
            3'b010: begin
                win_s     = OWN_DM;
                mem_we    = dm_we;
                mem_mode  = dm_mode;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            3'b100: begin
                win_s     = OWN_DBG;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: begin
                win_s = OWN_NONE;
            end
        endcase
    end

    // Next-state: read owner tag, loader lock, IF starvation counter.
    always_comb begin
        owner_d  = OWN_NONE;
        lock_d   = lock_q;
        starve_d = starve_q;
        if (mem_en && !mem_we) begin
            owner_d = win_s;
        end else begin
            owner_d = OWN_NONE;
        end
        if (lock_q) begin
            lock_d = dbg_lock;
        end else begin
            lock_d = gnt_s[REQ_DBG] && dbg_lock;
        end
        if (gnt_s[REQ_IF]) begin
            starve_d = 4'd0;
        end else if (if_req) begin
            starve_d = sat_inc(starve_q, STARVE_LIM);
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_NONE;
            lock_q   <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            lock_q   <= lock_d;
            starve_q <= starve_d;
        end
    end

    // Read-return routing: the owner tag from last cycle qualifies RAM data.
    always_comb begin
        if_rvalid  = (owner_q == OWN_IF);
        dm_rvalid  = (owner_q == OWN_DM);
        dbg_rvalid = (owner_q == OWN_DBG);
        rdata      = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a write-first RAM model and
// a rule-level reference model of arbitration, starvation, lock and read return.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [1:0]  dm_mode = 2'd2;
    logic [31:0] if_addr = 32'd0, dm_addr = 32'd0, dbg_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0, dbg_wdata = 32'd0;
    logic        if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, dm_stall;
    logic        dbg_gnt, dbg_rvalid, dbg_stall, mem_en, mem_we;
    logic [1:0]  mem_mode;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] ram [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        ram_init = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int m_starve = 0;
    bit m_lock = 1'b0;
    int m_pend = 0;
    logic [31:0] m_pend_word = 32'd0;

    logic        s_if_gnt, s_dm_gnt, s_dbg_gnt, s_if_stall, s_dm_stall;
    logic        s_if_rvalid, s_dm_rvalid;
    logic [1:0]  s_mem_mode;
    logic [31:0] s_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(32), .ADDR_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_mode(dm_mode), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_stall(dm_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_stall(dbg_stall),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        if (i == 64) v = 32'hDEADBEEF;
        else v = {16'(i) ^ 16'h5A5A, 16'(i)};
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] mode, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (mode)
            2'd0:    r[int'(off) * 8 +: 8] = wd[7:0];
            2'd1:    r[int'(off[1]) * 16 +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Write-first synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[11:2]] <= merge(ram[mem_addr[11:2]], mem_wdata, mem_mode, mem_addr[1:0]);
                mem_rdata <= merge(ram[mem_addr[11:2]], mem_wdata, mem_mode, mem_addr[1:0]);
            end else begin
                mem_rdata <= ram[mem_addr[11:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_lock = 1'b0;
        m_pend = 0;
    endtask

    // One clock: check mid-cycle against the model, then advance the model over the edge.
    task automatic cycle(input string tag);
        int w;
        logic we_w;
        logic [1:0] md_w;
        logic [31:0] a_w, d_w;
        #4;
        if (m_lock) w = dbg_req ? 3 : 0;
        else if (if_req && m_starve == SMAX) w = 1;
        else if (dbg_req) w = 3;
        else if (dm_req) w = 2;
        else if (if_req) w = 1;
        else w = 0;
        we_w = 1'b0; md_w = 2'd2; a_w = if_addr; d_w = 32'd0;
        if (w == 2) begin we_w = dm_we; md_w = dm_mode; a_w = dm_addr; d_w = dm_wdata; end
        if (w == 3) begin we_w = dbg_we; a_w = dbg_addr; d_w = dbg_wdata; end
        chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(w == 1));
        chk({tag, ".dm_gnt"}, 32'(dm_gnt), 32'(w == 2));
        chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(w == 3));
        chk({tag, ".stalls"}, {29'd0, dbg_stall, dm_stall, if_stall},
            {29'd0, dbg_req && w != 3, dm_req && w != 2, if_req && w != 1});
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(w != 0));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(we_w));
        chk({tag, ".mem_addr"}, mem_addr, a_w);
        chk({tag, ".mem_mode"}, 32'(mem_mode), 32'(md_w));
        if (we_w) chk({tag, ".mem_wdata"}, mem_wdata, d_w);
        chk({tag, ".rvalid"}, {29'd0, dbg_rvalid, dm_rvalid, if_rvalid},
            {29'd0, m_pend == 3, m_pend == 2, m_pend == 1});
        chk({tag, ".one_rv"}, 32'(int'(if_rvalid) + int'(dm_rvalid) + int'(dbg_rvalid) <= 1), 32'd1);
        if (m_pend != 0) chk({tag, ".rdata"}, rdata, m_pend_word);
        s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_dbg_gnt = dbg_gnt;
        s_if_stall = if_stall; s_dm_stall = dm_stall;
        s_if_rvalid = if_rvalid; s_dm_rvalid = dm_rvalid;
        s_mem_mode = mem_mode; s_rdata = rdata;
        @(posedge clk);
        if (w != 0 && we_w) ref_mem[a_w[11:2]] = merge(ref_mem[a_w[11:2]], d_w, md_w, a_w[1:0]);
        if (w != 0 && !we_w) begin
            m_pend = w;
            m_pend_word = ref_mem[a_w[11:2]];
        end else begin
            m_pend = 0;
        end
        if (m_lock) m_lock = dbg_lock;
        else m_lock = (w == 3) && dbg_lock;
        if (w == 1) m_starve = 0;
        else if (if_req) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dbg_req = 1'b0;
        dbg_we = 1'b0; dbg_lock = 1'b0; dm_mode = 2'd2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        @(posedge clk);
        @(posedge clk);
        ram_init = 1'b0;
        #1;
        rst = 1'b1;

        // Reset release, idle port.
        cycle("idle");
        chk("idle.gnts", {29'd0, s_dbg_gnt, s_dm_gnt, s_if_gnt}, 32'd0);

        // Reset asserted while an IF read is in flight drops the return.
        if_req = 1'b1; if_addr = 32'h40;
        cycle("if_rd");
        rst = 1'b0;
        if_req = 1'b0;
        model_reset();
        #4;
        chk("rst_mid.if_rvalid", 32'(if_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("post_rst");
        chk("post_rst.if_rvalid", 32'(s_if_rvalid), 32'd0);

        // DM beats IF; DM read data comes back next cycle.
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_addr = 32'h100;
        cycle("dm_vs_if");
        chk("dm_vs_if.dm_gnt", 32'(s_dm_gnt), 32'd1);
        chk("dm_vs_if.if_stall", 32'(s_if_stall), 32'd1);
        idle_inputs();
        cycle("dm_ret");
        chk("dm_ret.dm_rvalid", 32'(s_dm_rvalid), 32'd1);
        chk("dm_ret.rdata", s_rdata, 32'hDEADBEEF);
        chk("dm_ret.if_rvalid", 32'(s_if_rvalid), 32'd0);

        // Starvation: clear counter with a lone IF read, then contend.
        if_req = 1'b1;
        cycle("if_alone");
        dm_req = 1'b1; dm_addr = 32'h104;
        for (int i = 0; i < 5; i++) begin
            cycle("starve");
            chk("starve.if_gnt", 32'(s_if_gnt), 32'(i == 4));
            chk("starve.dm_stall", 32'(s_dm_stall), 32'(i == 4));
        end
        cycle("starve_after");
        chk("starve_after.if_gnt", 32'(s_if_gnt), 32'd0);

        // Locked loader write; IF and DM shut out through the unlock cycle.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
        dbg_addr = 32'h200; dbg_wdata = 32'h12345678; dm_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin dbg_lock = 1'b0; dbg_req = 1'b0; end
            cycle("lock");
            chk("lock.if_dm_gnt", {30'd0, s_dm_gnt, s_if_gnt}, 32'd0);
            chk("lock.dbg_gnt", 32'(s_dbg_gnt), 32'(i < 3));
        end
        cycle("unlock_if");
        chk("unlock_if.if_gnt", 32'(s_if_gnt), 32'd1);
        if_req = 1'b0;
        cycle("dm_rd200");
        idle_inputs();
        cycle("dm_ret200");
        chk("dm_ret200.rdata", s_rdata, 32'h12345678);
        chk("dm_ret200.dm_rvalid", 32'(s_dm_rvalid), 32'd1);

        // Byte store then immediate read.
        dm_req = 1'b1; dm_we = 1'b1; dm_mode = 2'd0; dm_addr = 32'h301; dm_wdata = 32'h000000AB;
        cycle("byte_wr");
        chk("byte_wr.mem_mode", 32'(s_mem_mode), 32'd0);
        chk("byte_wr.dm_gnt", 32'(s_dm_gnt), 32'd1);
        dm_we = 1'b0; dm_mode = 2'd2; dm_addr = 32'h300;
        cycle("byte_rd");
        chk("byte_rd.dm_gnt", 32'(s_dm_gnt), 32'd1);
        idle_inputs();
        cycle("byte_ret");
        chk("byte_ret.dm_rvalid", 32'(s_dm_rvalid), 32'd1);
        chk("byte_ret.byte1", 32'(s_rdata[15:8]), 32'hAB);

        // Alternating IF/DM reads every cycle.
        for (int i = 0; i < 10; i++) begin
            if_req = (i % 2 == 0); dm_req = (i % 2 == 1);
            if_addr = 32'($urandom_range(0, 1023)) << 2;
            dm_addr = 32'($urandom_range(0, 1023)) << 2;
            cycle("alt");
        end
        idle_inputs();
        cycle("alt_end");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if_req = ($urandom_range(0, 3) != 0);
            dm_req = ($urandom_range(0, 2) != 0);
            dbg_req = ($urandom_range(0, 4) == 0);
            dm_we = $urandom_range(0, 1) == 1;
            dbg_we = $urandom_range(0, 1) == 1;
            dbg_lock = ($urandom_range(0, 3) == 0);
            dm_mode = 2'($urandom_range(0, 2));
            if_addr = 32'($urandom_range(0, 1023)) << 2;
            dm_addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            dbg_addr = 32'($urandom_range(0, 63)) << 2;
            dm_wdata = $urandom;
            dbg_wdata = $urandom;
            cycle("rand");
        end
        idle_inputs();
        cycle("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
